// File: rtl/wb_ram_burst.sv
// Wishbone B3 word-organised RAM slave with byte lanes, classic cycles and
// registered-feedback incrementing bursts (linear, wrap-4/8/16).
module wb_ram_burst #(
    parameter int dw    = 32,
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o
);

    localparam int words = depth / 4;
    localparam int ww    = aw - 2;

    logic [dw-1:0] mem [0:words-1];

    logic          valid;
    logic          burst;
    logic          in_burst;
    logic [ww-1:0] adr_word;
    logic [ww-1:0] rd_adr;
    logic [ww-1:0] next_adr;
    logic [ww-1:0] next_adr_d;
    logic          unused_adr_lo;

    // Handshake: a beat is requested while cyc & stb are high and completes on
    // the rising edge where ack is also high; the master then advances its
    // address. During an incrementing burst ack is held so one beat completes
    // per cycle, and the read pipeline runs one word ahead via next_adr.
    assign valid         = wb_cyc_i & wb_stb_i;
    assign burst         = valid & (wb_cti_i == 3'b010);
    assign in_burst      = wb_ack_o & burst;
    assign adr_word      = wb_adr_i[aw-1:2];
    assign rd_adr        = in_burst ? next_adr : adr_word;
    assign unused_adr_lo = ^wb_adr_i[1:0];
    assign wb_err_o      = 1'b0;

    // Wrapping bursts only advance the low address bits inside the wrap window.
    always_comb begin
        next_adr_d = rd_adr + ww'(1);
        case (wb_bte_i)
            2'b01:   next_adr_d = {rd_adr[ww-1:2], rd_adr[1:0] + 2'd1};
            2'b10:   next_adr_d = {rd_adr[ww-1:3], rd_adr[2:0] + 3'd1};
            2'b11:   next_adr_d = {rd_adr[ww-1:4], rd_adr[3:0] + 4'd1};
            default: next_adr_d = rd_adr + ww'(1);
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            next_adr <= '0;
        end else begin
            wb_ack_o <= valid & (!wb_ack_o | burst);
            next_adr <= next_adr_d;
            if (valid) begin
                wb_dat_o <= mem[rd_adr];
            end
        end
    end

    // Only acknowledged beats commit; a read of the same word sees old data.
    always_ff @(posedge wb_clk_i) begin
        if (valid & wb_we_i & wb_ack_o) begin
            for (int n = 0; n < 4; n++) begin
                if (wb_sel_i[n]) begin
                    mem[adr_word][8*n +: 8] <= wb_dat_i[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_burst.sv
// Bench for wb_ram_burst: directed vector table, hand-written burst/abort
// sequences, and randomised traffic against a shadow memory.
module tb_wb_ram_burst;

  localparam int depth = 1024;
  localparam int aw    = 10;
  localparam int words = depth / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [aw-1:0] adr;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;

  logic [31:0] shadow [words];
  logic [31:0] wbuf [256];
  logic [31:0] rbuf [256];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  // clock / reset
  always #5 clk = ~clk;

  wb_ram_burst #(.depth(depth)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_w),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .wb_err_o (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Master-side address sequence for a burst, from the wrap window size.
  function automatic int next_word(input int w, input logic [1:0] b);
    int n;
    n = (b == 2'b00) ? words : (2 << b);
    return (w - (w % n)) + ((w % n) + 1) % n;
  endfunction

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  task automatic drive_beat(input int a, input bit is_we, input bit is_burst,
                            input logic [1:0] b, input int i, input int beats,
                            input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = is_we; sel = s; bte = b;
    adr = aw'(a);
    dat_w = wbuf[i];
    if (!is_burst) cti = 3'b000;
    else if (i == beats - 1) cti = 3'b111;
    else cti = 3'b010;
  endtask

  // Driver: one Wishbone cycle (classic or burst); checks latency, burst
  // continuity, read data against the shadow, and ack release afterwards.
  task automatic xfer(input int start_adr, input bit is_we, input bit is_burst,
                      input logic [1:0] b, input int beats, input logic [3:0] s,
                      input string tag);
    int w;
    int i;
    int budget;
    int last_ack;
    w = start_adr / 4; i = 0; budget = 0; last_ack = 0;
    drive_beat(start_adr, is_we, is_burst, b, 0, beats, s);
    while (i < beats && budget < beats * 4 + 8) begin
      @(negedge clk);
      budget++;
      if (ack) begin
        check({tag, " err"}, 32'(err), 32'd0);
        if (i == 0) check({tag, " ack latency"}, 32'(budget), 32'd2);
        else check({tag, " ack gap"}, 32'(budget - last_ack), 32'd1);
        last_ack = budget;
        if (is_we) begin
          for (int n = 0; n < 4; n++)
            if (s[n]) shadow[w][8*n +: 8] = wbuf[i][8*n +: 8];
        end else begin
          rbuf[i] = dat_r;
          check({tag, " rd"}, dat_r, shadow[w]);
        end
        i++;
        w = next_word(w, b);
        @(posedge clk); #1;
        if (i < beats) drive_beat(w * 4, is_we, is_burst, b, i, beats, s);
        else bus_idle();
      end else begin
        @(posedge clk); #1;
      end
    end
    bus_idle();
    check({tag, " beats acked"}, 32'(i), 32'(beats));
    @(negedge clk);
    check({tag, " ack release"}, 32'(ack), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int kind;
    int beats;
    int n;
    bit rw;
    bit bst;
    logic [1:0] b;
    logic [3:0] s;

    vecs[0] = '{1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 10'h010, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 10'h020, 4'hF, 32'h11223344, 32'h0};
    vecs[3] = '{1'b1, 10'h020, 4'h5, 32'hAABBCCDD, 32'h0};
    vecs[4] = '{1'b0, 10'h020, 4'hF, 32'h0,        32'h11BB33DD};
    vecs[5] = '{1'b1, 10'h024, 4'h8, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{1'b0, 10'h024, 4'hF, 32'h0,        32'hFF000000};
    vecs[7] = '{1'b1, 10'h3FC, 4'h6, 32'h12345678, 32'h0};
    vecs[8] = '{1'b0, 10'h3FC, 4'hF, 32'h0,        32'h00345600};
    vecs[9] = '{1'b0, 10'h013, 4'hF, 32'h0,        32'hDEADBEEF};

    for (int k = 0; k < words; k++) shadow[k] = 32'h0;
    for (int k = 0; k < 256; k++) wbuf[k] = 32'h0;

    // Reset with a request pending: outputs stay cleared until release.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = '0; dat_w = '0;
    cti = 3'b000; bte = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ack", 32'(ack), 32'd0);
    check("reset dat", dat_r, 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ack after reset", 32'(ack), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("ack drop after reset", 32'(ack), 32'd0);
    @(posedge clk); #1;

    xfer(0, 1'b1, 1'b1, 2'b00, 256, 4'hF, "fill");

    for (int v = 0; v < 10; v++) begin
      wbuf[0] = vecs[v].wdat;
      xfer(int'(vecs[v].adr), vecs[v].we, 1'b0, 2'b00, 1, vecs[v].sel, "vec");
      if (!vecs[v].we) check($sformatf("vec%0d data", v), rbuf[0], vecs[v].exp);
    end

    // Linear burst across the top of memory back to word 0.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'(k);
    xfer(10'h3F0, 1'b1, 1'b1, 2'b00, 8, 4'hF, "lin wr");
    xfer(10'h3F0, 0, 1'b1, 2'b00, 8, 4'hF, "lin rd");
    for (int k = 0; k < 8; k++) check($sformatf("lin beat%0d", k), rbuf[k], 32'(k));

    // Wrap bursts starting mid-window at 0x108.
    for (int k = 0; k < 16; k++) wbuf[k] = 32'hC0DE0000 + 32'(k);
    xfer(10'h100, 1'b1, 1'b1, 2'b00, 16, 4'hF, "wrap wr");
    for (int bb = 1; bb < 4; bb++) begin
      n = 2 << bb;
      xfer(10'h108, 0, 1'b1, 2'(bb), n, 4'hF, "wrap rd");
      for (int k = 0; k < n; k++)
        check($sformatf("wrap%0d beat%0d", n, k), rbuf[k], 32'hC0DE0000 + 32'((2 + k) % n));
    end

    // Strobe dropped mid-burst: stale ack, but the unstrobed beat never writes.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 10'h200;
    dat_w = 32'h55; cti = 3'b010; bte = 2'b00;
    @(negedge clk);
    check("abort first ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort beat0 ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    stb = 1'b0; adr = 10'h204; dat_w = 32'h66;
    @(negedge clk);
    check("abort stale ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("abort ack drop", 32'(ack), 32'd0);
    @(posedge clk); #1;
    shadow[10'h200 / 4] = 32'h55;
    xfer(10'h200, 0, 1'b0, 2'b00, 1, 4'hF, "abort rd0");
    check("abort beat0 data", rbuf[0], 32'h55);
    xfer(10'h204, 0, 1'b0, 2'b00, 1, 4'hF, "abort rd1");
    check("abort beat1 data", rbuf[0], 32'h0);

    // Randomised mixed traffic.
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 3);
      bst = (kind >= 2);
      rw = 1'($urandom_range(0, 1));
      b = 2'($urandom_range(0, 3));
      beats = bst ? $urandom_range(1, 16) : 1;
      s = rw ? 4'($urandom_range(0, 15)) : 4'hF;
      for (int k = 0; k < beats; k++) wbuf[k] = $urandom;
      xfer($urandom_range(0, 1023), rw, bst, b, beats, s, "rand");
    end

    xfer(0, 0, 1'b1, 2'b00, 256, 4'hF, "final sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
